uart_tx: RTL and testbench
==========================

// Module: uart_tx
// PURPOSE
// - Serial transmitter for the Hack I/O space: parallel-in, bit-serial-out (8N1 UART framing).
// - Drives the board's TX pin; the CPU-facing memory-mapped register logic writes a byte via load/in.
// - Reads the held byte out one bit per bit-period, LSB first, and reports busy until the stop bit ends.
// PARAMETERS
// - CLKS_PER_BIT  default 217  clk cycles per UART bit (25 MHz / 115200 baud); legal range 2..65535
// PORTS
// - clk     in   1  system clock; all state changes on posedge
// - rst_n   in   1  asynchronous, active-low reset
// - in      in   8  byte to send; sampled only on an accepted load
// - load    in   1  request to send in; accepted only when busy==0
// - tx      out  1  serial line, idle high
// - busy    out  1  high from the cycle after an accepted load through the last stop-bit cycle
// BEHAVIOUR
// - Reset (async assert, sync-released by the system): tx=1, busy=0, state=IDLE, counters=0, shift reg=0.
// - States: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
// - IDLE: tx=1, busy=0. On posedge with load=1: latch in into shift reg, go to START, clear baud counter.
// - Latency: tx falls and busy rises on the same posedge that accepts load (one clk after load is presented).
// - START: tx=0 for exactly CLKS_PER_BIT cycles.
// - DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles; bit index 0..7, no wrap past 7.
// - STOP: tx=1 for CLKS_PER_BIT cycles; busy=1 throughout; on last cycle return to IDLE (busy=0 next edge).
// - Frame length: 10*CLKS_PER_BIT cycles (11*CLKS_PER_BIT with parity).
// - Baud counter: width $clog2(CLKS_PER_BIT), counts 0..CLKS_PER_BIT-1, wraps to 0 at each bit boundary.
// - load while busy=1: ignored, in not sampled, frame in progress unaffected; no queuing.
// - Back-to-back: load held high across the IDLE cycle after STOP starts next frame; min one idle tx=1 clk
//   between frames is NOT guaranteed beyond the stop bit itself (stop bit is the only separator).
// - in changes while busy: no effect (byte held in internal shift reg).
// - rst_n asserted mid-frame: tx=1 and busy=0 immediately (asynchronous), frame aborted, no resume.
// - tx is registered (no combinational path from load/in to tx); glitch-free.
// CONFIGURATION
// - Macro UART_TX_PARITY_EN:
//   - defined: PARITY state inserted between DATA and STOP, tx = even parity (^byte) for CLKS_PER_BIT cycles.
//   - undefined: no PARITY state, 8N1 framing, parity logic not compiled.
// STRUCTURE
// - Shared header uart_defs.vh: state encodings (IDLE/START/DATA/PARITY/STOP, 3-bit), DATA_BITS=8,
//   default CLKS_PER_BIT; also used by the future uart_rx.
// - One sub-module: uart_baud_gen (counter, tick pulse on CLKS_PER_BIT-1, sync clear input, rst_n).
// - uart_tx holds FSM, 8-bit shift register, 3-bit bit index, tx/busy output registers.
// TESTING (bench uses CLKS_PER_BIT=4; clk toggles every #1; compare against a bit-period reference model)
// - Reset: rst_n=0 for 3 clks with load=1, in=8'hFF -> tx=1, busy=0 throughout; no frame starts.
// - Single byte 8'h55, load 1 clk -> tx per 4-clk slot: 0,1,0,1,0,1,0,1,0,1; busy high exactly 40 clks.
// - Ignore while busy: send 8'hA3, pulse load with in=8'h00 at clk 10 -> line carries only 0xA3 frame
//   (0,1,1,0,0,0,1,0,1,1); no second frame.
// - Back-to-back: load held high, in=8'h01 then 8'h80 -> two frames, second start bit begins the clk after
//   first stop bit ends; 80 clks total busy except one idle clk.
// - Reset mid-frame: assert rst_n=0 during data bit 3 of 8'hF0 -> tx=1, busy=0 in same cycle; after
//   release, new load of 8'h0F yields a clean full frame.
// - UART_TX_PARITY_EN defined: send 8'h07 -> parity slot tx=1 (three ones), frame 44 clks; 8'h03 -> parity 0.

Source files
------------

// File: rtl/uart_tx_pkg.sv
// Shared UART definitions: state encoding, data width, default bit period.
// Intended for reuse by the receiver as well as the transmitter.
package uart_tx_pkg;

    localparam int DATA_BITS            = 8;
    localparam int DEFAULT_CLKS_PER_BIT = 217;   // 25 MHz / 115200 baud

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_t;

    function automatic logic even_parity(input logic [DATA_BITS-1:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/uart_tx_baud_gen.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and wraps, tick is high on the last count.
// Latency: tick is combinational from the counter register; clear takes effect next edge. No backpressure.
// Backpressure: none; the counter free-runs and is restarted by a synchronous clear.
module uart_baud_gen
    import uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);

    localparam int                CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter, LSB first; UART_TX_PARITY_EN adds an even-parity bit before stop.
// Latency: tx falls and busy rises on the edge that accepts load; frame is 10 (11) bit periods.
// Backpressure: load is only accepted while busy is low; loads during a frame are dropped, never queued.
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATA_BITS-1:0] in,
    input  logic                 load,
    output logic                 tx,
    output logic                 busy
);

    uart_state_t          state;
    logic [DATA_BITS-1:0] shift_q;
    logic [2:0]           bit_idx;
    logic                 baud_clr;
    logic                 tick;
`ifdef UART_TX_PARITY_EN
    logic                 parity_q;
`endif

    // Restart the bit period exactly on the accepting edge so START lasts a full period.
    assign baud_clr = (state == ST_IDLE) && load;

    uart_baud_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (baud_clr),
        .tick  (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            shift_q  <= '0;
            bit_idx  <= '0;
            tx       <= 1'b1;
            busy     <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    tx   <= 1'b1;
                    busy <= 1'b0;
                    if (load) begin
                        shift_q  <= in;
                        bit_idx  <= '0;
                        tx       <= 1'b0;
                        busy     <= 1'b1;
                        state    <= ST_START;
`ifdef UART_TX_PARITY_EN
                        parity_q <= even_parity(in);
`endif
                    end
                end
                ST_START: begin
                    if (tick) begin
                        tx    <= shift_q[0];
                        state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        if (bit_idx == 3'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                            tx    <= parity_q;
                            state <= ST_PARITY;
`else
                            tx    <= 1'b1;
                            state <= ST_STOP;
`endif
                        end else begin
                            // Next bit is presented while the register shifts toward bit 0.
                            tx      <= shift_q[1];
                            shift_q <= shift_q >> 1;
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                ST_PARITY: begin
                    if (tick) begin
                        tx    <= 1'b1;
                        state <= ST_STOP;
                    end
                end
`endif
                ST_STOP: begin
                    if (tick) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx at CLKS_PER_BIT=4; expected line levels come from a
// frame-slot model (start, data LSB first, optional even parity, stop) evaluated per clock.
`timescale 1ns/100ps
module tb_uart_tx;

    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int SLOTS = 11;
`else
    localparam int SLOTS = 10;
`endif
    localparam int FRAME = SLOTS * CPB;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] in_dat = 8'h00;
    logic       load = 1'b0;
    logic       tx;
    logic       busy;

    int tests = 0;
    int fails = 0;

    uart_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .in    (in_dat),
        .load  (load),
        .tx    (tx),
        .busy  (busy)
    );

    always #1 clk = ~clk;

    // Line level expected in a given bit slot of the frame carrying byte b.
    function automatic logic exp_bit(input logic [7:0] b, input int slot);
        int ones;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += (b >> i) & 1;
        if (slot == 0) return 1'b0;
        if (slot <= 8) return 1'(((b >> (slot - 1)) & 1) != 0);
        if (SLOTS == 11 && slot == 9) return 1'((ones % 2) != 0);
        return 1'b1;
    endfunction

    task automatic chk(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " tx"}, tx, 1'b1);
        chk({tag, " busy"}, busy, 1'b0);
    endtask

    // Call right after driving load=1/in=b at a negedge. Checks every clock of the frame.
    // hold: keep load high with in=next_in throughout; otherwise pulse load with poke_dat at poke_at.
    task automatic check_frame(input logic [7:0] b, input bit hold, input logic [7:0] next_in,
                               input int poke_at, input logic [7:0] poke_dat);
        for (int k = 0; k < FRAME; k++) begin
            @(negedge clk);
            chk($sformatf("byte %02h clk %0d tx", b, k), tx, exp_bit(b, k / CPB));
            chk($sformatf("byte %02h clk %0d busy", b, k), busy, 1'b1);
            if (hold) begin
                load = 1'b1; in_dat = next_in;
            end else if (k == poke_at) begin
                load = 1'b1; in_dat = poke_dat;
            end else begin
                load = 1'b0; in_dat = $urandom_range(0, 255);
            end
        end
    endtask

    task automatic send(input logic [7:0] b, input int poke_at, input logic [7:0] poke_dat);
        @(negedge clk);
        load = 1'b1; in_dat = b;
        check_frame(b, 1'b0, 8'h00, poke_at, poke_dat);
        @(negedge clk);
        load = 1'b0;
        chk_idle($sformatf("after %02h", b));
        @(negedge clk);
        chk_idle($sformatf("after %02h +1", b));
    endtask

    initial begin
        logic [7:0] rb;

        // Reset held with load asserted: nothing may start.
        load = 1'b1; in_dat = 8'hFF; rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_idle($sformatf("reset clk %0d", i));
        end
        load = 1'b0; rst_n = 1'b1;
        @(negedge clk);
        chk_idle("post reset");
        @(negedge clk);
        chk_idle("post reset +1");

        // Directed single byte, and a dropped load at clk 10 of an 0xA3 frame.
        send(8'h55, -1, 8'h00);
        send(8'hA3, 10, 8'h00);

        // Dropped load on the very last stop-bit clock.
        send(8'h3C, FRAME - 1, 8'hC3);

        // Parity-sensitive bytes.
        send(8'h07, -1, 8'h00);
        send(8'h03, -1, 8'h00);

        // Back-to-back with load held: exactly one idle clock between frames.
        @(negedge clk);
        load = 1'b1; in_dat = 8'h01;
        check_frame(8'h01, 1'b1, 8'h80, -1, 8'h00);
        @(negedge clk);
        chk_idle("b2b gap");
        load = 1'b1; in_dat = 8'h80;
        check_frame(8'h80, 1'b0, 8'h00, -1, 8'h00);
        @(negedge clk);
        load = 1'b0;
        chk_idle("b2b end");

        // Asynchronous reset during data bit 3 of 0xF0.
        @(negedge clk);
        load = 1'b1; in_dat = 8'hF0;
        for (int k = 0; k < 4 * CPB + 2; k++) begin
            @(negedge clk);
            load = 1'b0;
            chk($sformatf("abort clk %0d tx", k), tx, exp_bit(8'hF0, k / CPB));
        end
        #0.4 rst_n = 1'b0;
        #0.2 chk_idle("async abort");
        @(negedge clk);
        chk_idle("abort held");
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_idle($sformatf("abort released %0d", i));
        end
        send(8'h0F, -1, 8'h00);

        // Random bytes with random dropped loads.
        for (int n = 0; n < 16; n++) begin
            rb = 8'($urandom_range(0, 255));
            send(rb, int'($urandom_range(0, FRAME - 1)), 8'($urandom_range(0, 255)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
